// File: rtl/laser_drop_pkg.sv
// Shared types and constants for the LaserDrop transmit path.
package laser_drop_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN,
        PAYLOAD,
        CSUM,
        GAP
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned QUEUE_DEPTH = 64;

    function automatic logic [7:0] clamp_len(input logic [7:0] size, input logic [7:0] max_len);
        return (size >= max_len) ? max_len : size;
    endfunction

endpackage

// File: rtl/ld_flush_timer.sv
// Saturating idle timer; terminal is high once TIMEOUT-1 is reached and holds until cleared.
module ld_flush_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic count_en,
    output logic terminal
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] TERM = W'(TIMEOUT - 1);

    logic [W-1:0] timer_q;
    logic [W-1:0] timer_d;

    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (count_en && (timer_q != TERM)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign terminal = (timer_q == TERM);

endmodule

// File: rtl/laser_tx_scheduler.sv
// Drains the LaserDrop byte queue into framed packets: SYNC, LEN, payload, [XOR checksum], gap.
// Optional checksum byte is built only when LASER_TX_CHECKSUM_EN is defined.
import laser_drop_pkg::*;

module laser_tx_scheduler #(
    parameter int unsigned MAX_PAYLOAD   = 16,
    parameter int unsigned FLUSH_TIMEOUT = 64,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  q_data,
    input  logic [7:0]  q_size,
    input  logic        q_empty,
    output logic        q_read,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] pkt_count
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    tx_state_t       state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      remain_q, remain_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [15:0]     pkt_count_q, pkt_count_d;
`ifdef LASER_TX_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    logic flush_tc;
    logic start;

    assign start = (state_q == IDLE) && enable &&
                   ((q_size >= MAX_LEN) || (!q_empty && flush_tc));

    ld_flush_timer #(
        .TIMEOUT (FLUSH_TIMEOUT)
    ) u_flush_timer (
        .clk      (clock),
        .srst     (reset),
        .clear    ((state_q != IDLE) || !enable || q_empty || start),
        .count_en (1'b1),
        .terminal (flush_tc)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        remain_d    = remain_q;
        gap_d       = gap_q;
        pkt_count_d = pkt_count_q;
`ifdef LASER_TX_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        q_read      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Safe to latch now: this block is the queue's only reader.
                    len_d    = clamp_len(q_size, MAX_LEN);
                    remain_d = clamp_len(q_size, MAX_LEN);
`ifdef LASER_TX_CHECKSUM_EN
                    csum_d   = 8'h00;
`endif
                    state_d  = SYNC;
                end
            end
            SYNC: begin
                tx_data  = SYNC_BYTE;
                tx_valid = 1'b1;
                if (tx_ready) state_d = LEN;
            end
            LEN: begin
                tx_data  = len_q;
                tx_valid = 1'b1;
                if (tx_ready) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                tx_data  = q_data;
                tx_valid = !q_empty;
                q_read   = !q_empty && tx_ready;
                if (q_read) begin
                    remain_d = remain_q - 8'd1;
`ifdef LASER_TX_CHECKSUM_EN
                    csum_d   = csum_q ^ q_data;
                    if (remain_q == 8'd1) state_d = CSUM;
`else
                    if (remain_q == 8'd1) begin
                        state_d     = GAP;
                        gap_d       = '0;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
`endif
                end
            end
`ifdef LASER_TX_CHECKSUM_EN
            CSUM: begin
                tx_data  = csum_q;
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_d     = GAP;
                    gap_d       = '0;
                    pkt_count_d = pkt_count_q + 16'd1;
                end
            end
`endif
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= 8'h00;
            remain_q    <= 8'h00;
            gap_q       <= '0;
            pkt_count_q <= 16'h0000;
`ifdef LASER_TX_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            remain_q    <= remain_d;
            gap_q       <= gap_d;
            pkt_count_q <= pkt_count_d;
`ifdef LASER_TX_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_laser_tx_scheduler.sv
// Directed bench for laser_tx_scheduler with a behavioural byte-queue model and wire capture.
module tb_laser_tx_scheduler;

`ifdef LASER_TX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  q_data;
    logic [7:0]  q_size;
    logic        q_empty;
    logic        q_read;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    // Queue model: tail written by stimulus, head advanced by the DUT's pops.
    logic [7:0] qmem [0:255];
    int q_head = 0;
    int q_tail = 0;

    assign q_size  = 8'(q_tail - q_head);
    assign q_empty = (q_tail == q_head);
    assign q_data  = qmem[q_head[7:0]];

    logic [7:0] cap [0:511];
    int cap_n = 0;
    int pop_cnt = 0;
    int bad_pop = 0;
    int stall_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    laser_tx_scheduler dut (
        .clock     (clk),
        .reset     (reset),
        .enable    (enable),
        .q_data    (q_data),
        .q_size    (q_size),
        .q_empty   (q_empty),
        .q_read    (q_read),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always @(posedge clk) begin
        if (q_read) begin
            q_head  <= q_head + 1;
            pop_cnt <= pop_cnt + 1;
            if (!tx_ready || q_empty) bad_pop <= bad_pop + 1;
        end
        if (tx_valid && tx_ready) begin
            cap[cap_n] <= tx_data;
            cap_n      <= cap_n + 1;
            $display("wire byte %0d: %02h", cap_n, tx_data);
        end
        if (prev_stall && tx_valid && (tx_data !== prev_data)) stall_err <= stall_err + 1;
        prev_stall <= tx_valid && !tx_ready;
        prev_data  <= tx_data;
    end

    task automatic push(input logic [7:0] b);
        qmem[q_tail[7:0]] = b;
        q_tail = q_tail + 1;
    endtask

    task automatic wait_idle(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (!(pkt_count == 16'(target) && !busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= budget) begin
            n_bad++;
            $display("FAIL %s timeout: pkt_count=%0d busy=%0b, required pkt_count=%0d idle", name, pkt_count, busy, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (tx_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_valid got %0b want 0", tx_valid); end
        n_cmp++; if (q_read !== 1'b0)     begin n_bad++; $display("FAIL reset_qread got %0b want 0", q_read); end
        n_cmp++; if (pkt_count !== 16'd0) begin n_bad++; $display("FAIL reset_pkt got %0d want 0", pkt_count); end
        n_cmp++; if (tx_data !== 8'h00)   begin n_bad++; $display("FAIL reset_data got %02h want 00", tx_data); end
        $display("test_reset done");
    endtask

    task automatic test_full_packet();
        int base, pp, k, g;
        logic [7:0] exp_b [0:31];
        base = cap_n; pp = pop_cnt;
        exp_b[0] = 8'hA5; exp_b[1] = 8'h10;
        for (int i = 0; i < 16; i++) exp_b[2+i] = 8'(i);
        exp_b[18] = 8'h00;
        for (int i = 0; i < 16; i++) push(8'(i));
        enable = 1'b1;
        k = 0;
        while (cap_n < base + 18 + CS && k < 200) begin @(negedge clk); k++; end
        n_cmp++; if (k >= 200) begin n_bad++; $display("FAIL full_wire_len got %0d want %0d", cap_n - base, 18 + CS); end
        n_cmp++; if (pkt_count !== 16'd1) begin n_bad++; $display("FAIL full_pkt got %0d want 1", pkt_count); end
        g = 0;
        while (busy && !tx_valid && g < 10) begin @(negedge clk); g++; end
        n_cmp++; if (g != 4 || busy !== 1'b0) begin n_bad++; $display("FAIL full_gap got %0d cycles busy=%0b want 4 then idle", g, busy); end
        for (int i = 0; i < 18 + CS; i++) begin
            n_cmp++;
            if (cap[base+i] !== exp_b[i]) begin n_bad++; $display("FAIL full_byte%0d got %02h want %02h", i, cap[base+i], exp_b[i]); end
        end
        n_cmp++; if (pop_cnt - pp != 16) begin n_bad++; $display("FAIL full_pops got %0d want 16", pop_cnt - pp); end
        $display("test_full_packet done");
    endtask

    task automatic test_flush();
        int base, k;
        logic [7:0] exp_b [0:7];
        exp_b[0] = 8'hA5; exp_b[1] = 8'h03; exp_b[2] = 8'h11; exp_b[3] = 8'h22; exp_b[4] = 8'h33; exp_b[5] = 8'h00;
        base = cap_n;
        push(8'h11); push(8'h22); push(8'h33);
        k = 0;
        while (!busy && k < 200) begin @(negedge clk); k++; end
        n_cmp++; if (k != 64) begin n_bad++; $display("FAIL flush_start got %0d cycles want 64", k); end
        wait_idle(2, 200, "flush_done");
        n_cmp++; if (cap_n - base != 5 + CS) begin n_bad++; $display("FAIL flush_len got %0d want %0d", cap_n - base, 5 + CS); end
        for (int i = 0; i < 5 + CS; i++) begin
            n_cmp++;
            if (cap[base+i] !== exp_b[i]) begin n_bad++; $display("FAIL flush_byte%0d got %02h want %02h", i, cap[base+i], exp_b[i]); end
        end
        $display("test_flush done");
    endtask

    task automatic test_forty();
        int base, off;
        base = cap_n;
        for (int i = 0; i < 40; i++) push(8'(8'h40 + i));
        wait_idle(5, 2000, "forty_done");
        off = 2 * (18 + CS);
        n_cmp++; if (cap_n - base != 46 + 3*CS) begin n_bad++; $display("FAIL forty_len got %0d want %0d", cap_n - base, 46 + 3*CS); end
        n_cmp++; if (q_size !== 8'd0) begin n_bad++; $display("FAIL forty_qsize got %0d want 0", q_size); end
        n_cmp++; if (cap[base+1] !== 8'h10) begin n_bad++; $display("FAIL forty_len1 got %02h want 10", cap[base+1]); end
        n_cmp++; if (cap[base+off] !== 8'hA5) begin n_bad++; $display("FAIL forty_sync3 got %02h want a5", cap[base+off]); end
        n_cmp++; if (cap[base+off+1] !== 8'h08) begin n_bad++; $display("FAIL forty_len3 got %02h want 08", cap[base+off+1]); end
        n_cmp++; if (cap[base+off+2] !== 8'h60) begin n_bad++; $display("FAIL forty_first3 got %02h want 60", cap[base+off+2]); end
        $display("test_forty done");
    endtask

    task automatic test_backpressure();
        int base, pp, k;
        logic [7:0] exp_b [0:31];
        logic [7:0] x;
        base = cap_n; pp = pop_cnt; x = 8'h00;
        exp_b[0] = 8'hA5; exp_b[1] = 8'h10;
        for (int i = 0; i < 16; i++) begin
            exp_b[2+i] = 8'(i*37 + 5);
            x = x ^ exp_b[2+i];
        end
        exp_b[18] = x;
        for (int i = 0; i < 16; i++) push(exp_b[2+i]);
        k = 0;
        while (!(pkt_count == 16'd6 && !busy) && k < 400) begin
            tx_ready = ~tx_ready;
            @(negedge clk);
            k++;
        end
        tx_ready = 1'b1;
        n_cmp++; if (k >= 400) begin n_bad++; $display("FAIL bp_timeout pkt_count=%0d want 6", pkt_count); end
        n_cmp++; if (stall_err != 0) begin n_bad++; $display("FAIL bp_stable got %0d changes want 0", stall_err); end
        n_cmp++; if (bad_pop != 0) begin n_bad++; $display("FAIL bp_badpop got %0d want 0", bad_pop); end
        n_cmp++; if (pop_cnt - pp != 16) begin n_bad++; $display("FAIL bp_pops got %0d want 16", pop_cnt - pp); end
        for (int i = 0; i < 18 + CS; i++) begin
            n_cmp++;
            if (cap[base+i] !== exp_b[i]) begin n_bad++; $display("FAIL bp_byte%0d got %02h want %02h", i, cap[base+i], exp_b[i]); end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_abort();
        int pp, k;
        pp = pop_cnt;
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        k = 0;
        while (pop_cnt - pp < 5 && k < 100) begin @(negedge clk); k++; end
        n_cmp++; if (pop_cnt - pp != 5) begin n_bad++; $display("FAIL abort_pops got %0d want 5", pop_cnt - pp); end
        reset = 1'b1; tx_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL abort_busy got %0b want 0", busy); end
        n_cmp++; if (tx_valid !== 1'b0)   begin n_bad++; $display("FAIL abort_valid got %0b want 0", tx_valid); end
        n_cmp++; if (q_read !== 1'b0)     begin n_bad++; $display("FAIL abort_qread got %0b want 0", q_read); end
        n_cmp++; if (pkt_count !== 16'd0) begin n_bad++; $display("FAIL abort_pkt got %0d want 0", pkt_count); end
        n_cmp++; if (q_size !== 8'd11)    begin n_bad++; $display("FAIL abort_qsize got %0d want 11", q_size); end
        enable = 1'b0; reset = 1'b0;
        $display("test_abort done");
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_flush();
        test_forty();
        test_backpressure();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
